// File: rtl/alu_pkg.sv
// Shared RV32I decode/ALU definitions: ALU op codes, comparator encodings,
// opcode constants and the decoded control-word type used by the decode stage and the ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // equalComp = {equal_inequal, Comparatorenable}
    localparam logic [1:0] EQ_BR  = 2'b11;
    localparam logic [1:0] NE_BR  = 2'b01;
    localparam logic [1:0] NO_CMP = 2'b00;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [3:0] alu_control;
        logic [1:0] equalComp;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic       is_branch;
        logic       illegal;
    } decode_t;

    // Register/immediate ALU op selected by funct3; alt picks SUB/SRA.
    function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Purely combinational RV32I instruction -> ALU control word decoder.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (f7 == 7'b0000000) begin
                    dec.alu_control = alu_op_from_f3(f3, 1'b0);
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.alu_control = alu_op_from_f3(f3, 1'b1);
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec.alu_src_b = 1'b1;
                // Only the shift forms carry a funct7; the rest is immediate bits.
                case (f3)
                    3'b000: dec.alu_control = ALU_ADD;
                    3'b001: begin
                        if (f7 == 7'b0000000) dec.alu_control = ALU_SLL;
                        else                  legal = 1'b0;
                    end
                    3'b101: begin
                        if (f7 == 7'b0000000)      dec.alu_control = ALU_SRL;
                        else if (f7 == 7'b0100000) dec.alu_control = ALU_SRA;
                        else                       legal = 1'b0;
                    end
                    default: dec.alu_control = alu_op_from_f3(f3, 1'b0);
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                dec.alu_control = ALU_ADD;
                dec.alu_src_b   = 1'b1;
            end
            OPC_AUIPC, OPC_JAL: begin
                dec.alu_control = ALU_ADD;
                dec.alu_src_a   = SRC_A_PC;
                dec.alu_src_b   = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_control = ALU_ADD;
                dec.alu_src_a   = SRC_A_ZERO;
                dec.alu_src_b   = 1'b1;
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1;
                case (f3)
                    3'b000:  begin dec.alu_control = ALU_XOR;  dec.equalComp = EQ_BR; end
                    3'b001:  begin dec.alu_control = ALU_XOR;  dec.equalComp = NE_BR; end
                    3'b100:  begin dec.alu_control = ALU_SLT;  dec.equalComp = EQ_BR; end
                    3'b101:  begin dec.alu_control = ALU_SLT;  dec.equalComp = NE_BR; end
                    3'b110:  begin dec.alu_control = ALU_SLTU; dec.equalComp = EQ_BR; end
                    3'b111:  begin dec.alu_control = ALU_SLTU; dec.equalComp = NE_BR; end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode-to-execute stage: decoder followed by a 2-entry skid buffer with
// valid/ready on both sides and flush. Optional counters under ALU_DECODE_STATS_EN.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_control,
    output logic [1:0]       equalComp,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic             is_branch,
    output logic             illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_DECODE_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_stall
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e state, state_next;

    decode_t            dec_p0;
    decode_t            head_dec_p1, spare_dec_p1;
    logic [XLEN-1:0]    head_pc_p1, spare_pc_p1;
    logic [TAG_W-1:0]   head_tag_p1, spare_tag_p1;
    logic               push, pop;

    alu_op_decoder u_dec (
        .instr (in_instr),
        .dec   (dec_p0)
    );

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    // Flush cancels both handshakes of its cycle.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) state_next = ONE;
                ONE: begin
                    if (push && !pop)      state_next = FULL;
                    else if (pop && !push) state_next = EMPTY;
                end
                FULL: if (pop) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // decode -> buffer: head drives the outputs, spare absorbs one stall cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            head_dec_p1  <= '0;
            head_pc_p1   <= '0;
            head_tag_p1  <= '0;
            spare_dec_p1 <= '0;
            spare_pc_p1  <= '0;
            spare_tag_p1 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_dec_p1 <= dec_p0;
                        head_pc_p1  <= in_pc;
                        head_tag_p1 <= in_tag;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_dec_p1 <= dec_p0;
                        head_pc_p1  <= in_pc;
                        head_tag_p1 <= in_tag;
                    end else if (push) begin
                        spare_dec_p1 <= dec_p0;
                        spare_pc_p1  <= in_pc;
                        spare_tag_p1 <= in_tag;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_dec_p1 <= spare_dec_p1;
                        head_pc_p1  <= spare_pc_p1;
                        head_tag_p1 <= spare_tag_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_control = head_dec_p1.alu_control;
    assign equalComp   = head_dec_p1.equalComp;
    assign alu_src_a   = head_dec_p1.alu_src_a;
    assign alu_src_b   = head_dec_p1.alu_src_b;
    assign is_branch   = head_dec_p1.is_branch;
    assign illegal     = head_dec_p1.illegal;
    assign out_pc      = head_pc_p1;
    assign out_tag     = head_tag_p1;

`ifdef ALU_DECODE_STATS_EN
    // Counters ignore flush; they only clear on reset and wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (pop)                    stat_issued <= stat_issued + 32'd1;
            if (out_valid && !out_ready) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: accepted inputs are modelled and queued,
// a monitor pops and compares every output transfer and checks hold-while-stalled.
module tb_alu_decode_stage;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc, out_pc;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [3:0]       alu_control;
    logic [1:0]       equalComp, alu_src_a;
    logic             alu_src_b, is_branch, illegal;
`ifdef ALU_DECODE_STATS_EN
    logic [31:0]      stat_issued, stat_stall;
`endif

    alu_decode_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .equalComp(equalComp),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .is_branch(is_branch), .illegal(illegal),
        .out_pc(out_pc), .out_tag(out_tag)
`ifdef ALU_DECODE_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic [1:0]  eq;
        logic [1:0]  sa;
        logic        sb;
        logic        br;
        logic        ill;
        logic [31:0] pc;
        logic [4:0]  tag;
    } exp_t;

    typedef enum {
        M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
        M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
        M_LOAD, M_STORE, M_JALR, M_AUIPC, M_LUI, M_JAL,
        M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU, M_ILL
    } mnem_e;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: instruction word -> assembler mnemonic -> control word
    function automatic mnem_e mnem(input logic [31:0] w);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        mnem_e rop[8];
        mnem_e iop[8];
        mnem_e bop[8];
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        rop = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
        iop = '{M_ADDI, M_SLLI, M_SLTI, M_SLTIU, M_XORI, M_SRLI, M_ORI, M_ANDI};
        bop = '{M_BEQ, M_BNE, M_ILL, M_ILL, M_BLT, M_BGE, M_BLTU, M_BGEU};
        case (opc)
            7'h33: begin
                if (f7 == 7'h00) return rop[f3];
                if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
                if (f7 == 7'h20 && f3 == 3'd5) return M_SRA;
                return M_ILL;
            end
            7'h13: begin
                if (f3 == 3'd1 && f7 != 7'h00) return M_ILL;
                if (f3 == 3'd5 && f7 == 7'h20) return M_SRAI;
                if (f3 == 3'd5 && f7 != 7'h00) return M_ILL;
                return iop[f3];
            end
            7'h03: return M_LOAD;
            7'h23: return M_STORE;
            7'h67: return M_JALR;
            7'h17: return M_AUIPC;
            7'h37: return M_LUI;
            7'h6F: return M_JAL;
            7'h63: return bop[f3];
            default: return M_ILL;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input logic [4:0] tag);
        mnem_e m;
        exp_t  e;
        m = mnem(w);
        e = '0;
        e.pc  = pc;
        e.tag = tag;
        case (m)
            M_AND, M_ANDI:                         e.alu = 4'd0;
            M_OR, M_ORI:                           e.alu = 4'd1;
            M_XOR, M_XORI, M_BEQ, M_BNE:           e.alu = 4'd3;
            M_SLL, M_SLLI:                         e.alu = 4'd4;
            M_SLT, M_SLTI, M_BLT, M_BGE:           e.alu = 4'd5;
            M_SUB:                                 e.alu = 4'd6;
            M_SLTU, M_SLTIU, M_BLTU, M_BGEU:       e.alu = 4'd7;
            M_SRL, M_SRLI:                         e.alu = 4'd8;
            M_SRA, M_SRAI:                         e.alu = 4'd9;
            M_ILL:                                 e.alu = 4'd0;
            default:                               e.alu = 4'd2;
        endcase
        case (m)
            M_BEQ, M_BLT, M_BLTU: e.eq = 2'b11;
            M_BNE, M_BGE, M_BGEU: e.eq = 2'b01;
            default:              e.eq = 2'b00;
        endcase
        case (m)
            M_AUIPC, M_JAL: e.sa = 2'b01;
            M_LUI:          e.sa = 2'b10;
            default:        e.sa = 2'b00;
        endcase
        case (m)
            M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
            M_LOAD, M_STORE, M_JALR, M_AUIPC, M_LUI, M_JAL: e.sb = 1'b1;
            default:                                        e.sb = 1'b0;
        endcase
        e.br  = (m inside {M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU});
        e.ill = (m == M_ILL);
        return e;
    endfunction

    // Input side: every accepted instruction becomes an expected output
    always @(negedge clk) begin
        if (reset || flush) sb_q.delete();
        else if (in_valid && in_ready) sb_q.push_back(model(in_instr, in_pc, in_tag));
    end

    // Output side: compare transfers in order, and check hold while stalled
    exp_t held;
    logic stall_prev = 1'b0;
    always @(negedge clk) begin
        exp_t act, e;
        act = {alu_control, equalComp, alu_src_a, alu_src_b, is_branch, illegal, out_pc, out_tag};
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_payload", {16'd0, act}, {16'd0, held});
            end
            if (out_valid && out_ready && !flush) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got pc %0h tag %0h, expected no entry", out_pc, out_tag);
                end else begin
                    e = sb_q.pop_front();
                    if (e.ill) begin
                        act.sa = 2'b00;
                        act.sb = 1'b0;
                        act.br = 1'b0;
                    end
                    check("entry", {16'd0, act}, {16'd0, e});
                end
            end
            stall_prev = out_valid && !out_ready && !flush;
            held = act;
        end
    end

    task automatic wait_accept();
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", k);
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        in_instr = w;
        in_pc    = $urandom;
        in_tag   = TAG_W'($urandom_range(0, 31));
        in_valid = 1'b1;
        wait_accept();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs[9];
        logic [31:0] w;
        int          p;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h17, 7'h37, 7'h6F, 7'h63};
        w = $urandom;
        p = $urandom_range(0, 9);
        if (p < 9) begin
            w[6:0] = opcs[p];
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    logic [31:0] d_instr[7];
    logic [6:0]  d_exp[7];
    logic [47:0] zero_out;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        logic took;
        int   k;
        d_instr = '{32'h003100B3, 32'h403100B3, 32'h40315093, 32'h00208463,
                    32'h0020D463, 32'h00000000, 32'h403110B3};
        // {alu_control, equalComp, illegal}
        d_exp   = '{{4'b0010, 2'b00, 1'b0}, {4'b0110, 2'b00, 1'b0}, {4'b1001, 2'b00, 1'b0},
                    {4'b0011, 2'b11, 1'b0}, {4'b0101, 2'b01, 1'b0}, {4'b0000, 2'b00, 1'b1},
                    {4'b0000, 2'b00, 1'b1}};
        zero_out = '0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_payload", {16'd0, alu_control, equalComp, alu_src_a, alu_src_b,
              is_branch, illegal, out_pc, out_tag}, {16'd0, zero_out});
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed decodes, each presented one cycle after acceptance
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(d_instr[i]);
            @(negedge clk);
            check("latency_valid", {63'd0, out_valid}, 64'd1);
            check("directed_ctl", {57'd0, alu_control, equalComp, illegal}, {57'd0, d_exp[i]});
            if (i == 2) check("srai_src_b", {63'd0, alu_src_b}, 64'd1);
            if (i == 3) check("beq_branch", {63'd0, is_branch}, 64'd1);
            @(posedge clk); #1;
        end

        // Backpressure: two fill the buffer, the third waits for release
        out_ready = 1'b0;
        send(rand_instr());
        send(rand_instr());
        @(negedge clk);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        in_instr = rand_instr(); in_pc = $urandom; in_tag = 5'd7; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("full_hold_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept();
        repeat (4) @(posedge clk);
        #1;
        check("drain_after_backpressure", 64'(sb_q.size()), 64'd0);

        // Flush a full buffer while an input is offered
        out_ready = 1'b0;
        send(rand_instr());
        send(rand_instr());
        in_instr = 32'h003100B3; in_pc = 32'hDEAD0000; in_tag = 5'd31; in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("flush_no_ghost", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk); #1;

        // Randomised traffic with backpressure and occasional flush
        took = 1'b1;
        repeat (800) begin
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_instr = rand_instr();
                in_pc    = $urandom;
                in_tag   = TAG_W'($urandom_range(0, 31));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            took = in_ready || flush;
            @(posedge clk); #1;
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("random_drain", 64'(sb_q.size()), 64'd0);

        // Reset in the middle of a stalled stream
        out_ready = 1'b0;
        send(rand_instr());
        send(rand_instr());
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        check("midreset_payload", {16'd0, alu_control, equalComp, alu_src_a, alu_src_b,
              is_branch, illegal, out_pc, out_tag}, {16'd0, zero_out});
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h40315093);
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
